// File: rtl/sprite_rect_plotter.sv
// Erase-then-draw rectangle sprite engine feeding vga_adapter one pixel per clock.
// The state/dx/dy registers describe the pixel currently on the outputs.
module sprite_rect_plotter #(
  parameter int unsigned RECT_W    = 2,
  parameter int unsigned RECT_H    = 8,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       erase_only,
  input  logic [7:0] new_x,
  input  logic [6:0] new_y,
  input  logic [2:0] new_colour,
  output logic       ready,
  output logic       done,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);

  localparam int unsigned XW  = 8;
  localparam int unsigned YW  = 7;
  localparam int unsigned CW  = 3;
  localparam int unsigned SXW = 9;
  localparam int unsigned SYW = 8;
  localparam int unsigned DW  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ERASE  = 2'd1,
    DRAW   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [DW-1:0] dx;
  logic [DW-1:0] dy;
  logic [DW-1:0] dx_nx;
  logic [DW-1:0] dy_nx;

  logic [XW-1:0] lat_x;
  logic [YW-1:0] lat_y;
  logic [CW-1:0] lat_colour;
  logic          lat_erase_only;

  logic          old_valid;
  logic [XW-1:0] old_x;
  logic [YW-1:0] old_y;

  logic          last_pixel;
  logic          row_end;

  logic [XW-1:0]  base_x;
  logic [YW-1:0]  base_y;
  logic [CW-1:0]  pix_colour;
  logic [SXW-1:0] sum_x;
  logic [SYW-1:0] sum_y;
  logic           ready_d;
  logic           done_d;
  logic           plot_d;
  logic [XW-1:0]  x_d;
  logic [YW-1:0]  y_d;
  logic [CW-1:0]  colour_d;

  assign row_end    = (dx == DW'(RECT_W - 1));
  assign last_pixel = row_end && (dy == DW'(RECT_H - 1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      dx    <= '0;
      dy    <= '0;
    end else begin
      state <= state_nx;
      dx    <= dx_nx;
      dy    <= dy_nx;
    end
  end

  // Next-state and scan counter logic.
  always_comb begin
    state_nx = state;
    dx_nx    = dx;
    dy_nx    = dy;
    case (state)
      IDLE: begin
        if (start) begin
          dx_nx = '0;
          dy_nx = '0;
          if (old_valid)       state_nx = ERASE;
          else if (erase_only) state_nx = FINISH;
          else                 state_nx = DRAW;
        end
      end
      ERASE, DRAW: begin
        if (last_pixel) begin
          dx_nx = '0;
          dy_nx = '0;
          if (state == ERASE && !lat_erase_only) state_nx = DRAW;
          else                                   state_nx = FINISH;
        end else if (row_end) begin
          dx_nx = '0;
          dy_nx = dy + DW'(1);
        end else begin
          dx_nx = dx + DW'(1);
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: next values of the registered pixel/handshake outputs.
  // On the acceptance cycle the latches are not yet loaded, so the raw inputs feed DRAW.
  always_comb begin
    base_x     = old_x;
    base_y     = old_y;
    pix_colour = BG_COLOUR;
    if (state_nx == DRAW) begin
      base_x     = (state == IDLE) ? new_x      : lat_x;
      base_y     = (state == IDLE) ? new_y      : lat_y;
      pix_colour = (state == IDLE) ? new_colour : lat_colour;
    end
    sum_x    = SXW'(base_x) + SXW'(dx_nx);
    sum_y    = SYW'(base_y) + SYW'(dy_nx);
    ready_d  = (state_nx == IDLE);
    done_d   = (state_nx == FINISH);
    plot_d   = 1'b0;
    x_d      = x;
    y_d      = y;
    colour_d = colour;
    if (state_nx == ERASE || state_nx == DRAW) begin
      plot_d   = (sum_x < SXW'(SCREEN_W)) && (sum_y < SYW'(SCREEN_H));
      x_d      = sum_x[XW-1:0];
      y_d      = sum_y[YW-1:0];
      colour_d = pix_colour;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      ready  <= 1'b1;
      done   <= 1'b0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      ready  <= ready_d;
      done   <= done_d;
      plot   <= plot_d;
      x      <= x_d;
      y      <= y_d;
      colour <= colour_d;
    end
  end

  // Request latch and record of the rectangle currently on screen.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_x          <= '0;
      lat_y          <= '0;
      lat_colour     <= '0;
      lat_erase_only <= 1'b0;
      old_valid      <= 1'b0;
      old_x          <= '0;
      old_y          <= '0;
    end else begin
      if (state == IDLE && start) begin
        lat_x          <= new_x;
        lat_y          <= new_y;
        lat_colour     <= new_colour;
        lat_erase_only <= erase_only;
      end
      if (state == FINISH) begin
        if (lat_erase_only) begin
          old_valid <= 1'b0;
        end else begin
          old_valid <= 1'b1;
          old_x     <= lat_x;
          old_y     <= lat_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_rect_plotter.sv
// Scoreboard bench for sprite_rect_plotter: expected pixel streams are queued at request time.
module tb_sprite_rect_plotter;

  logic       clk;
  logic       reset;
  logic       start;
  logic       erase_only;
  logic [7:0] new_x;
  logic [6:0] new_y;
  logic [2:0] new_colour;
  logic       ready;
  logic       done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  sprite_rect_plotter dut (
    .clock      (clk),
    .reset      (reset),
    .start      (start),
    .erase_only (erase_only),
    .new_x      (new_x),
    .new_y      (new_y),
    .new_colour (new_colour),
    .ready      (ready),
    .done       (done),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
    logic       d;
  } exp_t;

  exp_t q[$];
  int   tests;
  int   fails;

  logic       m_old_valid;
  logic [7:0] m_old_x;
  logic [6:0] m_old_y;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rect(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] col);
    logic [8:0] sx;
    logic [7:0] sy;
    exp_t       e;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 2; i++) begin
        sx = {1'b0, bx} + 9'(i);
        sy = {1'b0, by} + 8'(j);
        e  = '{x: sx[7:0], y: sy[6:0], c: col, p: (sx < 9'd160) && (sy < 8'd120), d: 1'b0};
        q.push_back(e);
      end
    end
  endtask

  // Queue expectations from the bench's own model, then issue the start pulse.
  task automatic request(input logic [7:0] nx, input logic [6:0] ny, input logic [2:0] nc,
                         input logic eo);
    if (m_old_valid) push_rect(m_old_x, m_old_y, 3'b000);
    if (!eo) push_rect(nx, ny, nc);
    q.push_back('{x: 8'd0, y: 7'd0, c: 3'd0, p: 1'b0, d: 1'b1});
    if (eo) begin
      m_old_valid = 1'b0;
    end else begin
      m_old_valid = 1'b1;
      m_old_x     = nx;
      m_old_y     = ny;
    end
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_before_start: got %b expected 1", ready);
    end
    start      = 1'b1;
    new_x      = nx;
    new_y      = ny;
    new_colour = nc;
    erase_only = eo;
    step();
    start = 1'b0;
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_drop: got %b expected 0", ready);
    end
  endtask

  // Pop and compare one expectation per cycle; optionally hammer start with junk meanwhile.
  task automatic run_stream(input int max_items, input bit noise);
    exp_t e;
    int   n;
    n = 0;
    while (q.size() > 0 && n < max_items) begin
      e = q.pop_front();
      n++;
      tests++;
      if (e.d) begin
        if (done !== 1'b1 || plot !== 1'b0) begin
          fails++;
          $display("FAIL done_pulse[%0d]: got done=%b plot=%b expected done=1 plot=0", n, done, plot);
        end
        start = 1'b0;
        step();
        tests++;
        if (ready !== 1'b1 || done !== 1'b0) begin
          fails++;
          $display("FAIL ready_return: got ready=%b done=%b expected ready=1 done=0", ready, done);
        end
      end else begin
        if ({x, y, colour, plot, done} !== {e.x, e.y, e.c, e.p, 1'b0}) begin
          fails++;
          $display("FAIL pixel[%0d]: got x=%0d y=%0d c=%b plot=%b done=%b expected x=%0d y=%0d c=%b plot=%b done=0",
                   n, x, y, colour, plot, done, e.x, e.y, e.c, e.p);
        end
        if (noise) begin
          start      = 1'($urandom_range(0, 1));
          new_x      = 8'($urandom_range(0, 255));
          new_y      = 7'($urandom_range(0, 127));
          new_colour = 3'($urandom_range(0, 7));
          erase_only = 1'($urandom_range(0, 1));
        end
        step();
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    tests++;
    if ({ready, done, plot, x, y, colour} !== {1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0}) begin
      fails++;
      $display("FAIL reset_values: got ready=%b done=%b plot=%b x=%0d y=%0d c=%b", ready, done, plot, x, y, colour);
    end
    reset = 1'b0;
    step();
    tests++;
    if (ready !== 1'b1 || plot !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got ready=%b plot=%b expected 1/0", ready, plot);
    end
  endtask

  task automatic test_first_draw();
    request(8'd10, 7'd20, 3'b100, 1'b0);
    run_stream(1000, 1'b0);
  endtask

  task automatic test_erase_draw();
    request(8'd11, 7'd20, 3'b010, 1'b0);
    run_stream(1000, 1'b0);
  endtask

  task automatic test_clip();
    request(8'd159, 7'd115, 3'b111, 1'b0);
    run_stream(1000, 1'b0);
  endtask

  task automatic test_busy_start();
    request(8'd30, 7'd40, 3'b001, 1'b0);
    run_stream(1000, 1'b1);
  endtask

  task automatic test_erase_only();
    request(8'd40, 7'd60, 3'b101, 1'b0);
    run_stream(1000, 1'b0);
    request(8'd0, 7'd0, 3'b111, 1'b1);
    run_stream(1000, 1'b0);
    request(8'd5, 7'd5, 3'b111, 1'b1);
    run_stream(1000, 1'b0);
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    request(8'd50, 7'd50, 3'b110, 1'b0);
    run_stream(4, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    q.delete();
    m_old_valid = 1'b0;
    tests++;
    if (plot !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_outputs: got plot=%b done=%b expected 0/0", plot, done);
    end
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) saw_done = 1'b1;
      step();
    end
    tests++;
    if (saw_done) begin
      fails++;
      $display("FAIL abort_no_done: got done pulse expected none");
    end
    request(8'd60, 7'd70, 3'b011, 1'b0);
    run_stream(1000, 1'b0);
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    m_old_valid = 1'b0;
    m_old_x     = '0;
    m_old_y     = '0;
    reset       = 1'b1;
    start       = 1'b0;
    erase_only  = 1'b0;
    new_x       = '0;
    new_y       = '0;
    new_colour  = '0;
    test_reset();
    test_first_draw();
    test_erase_draw();
    test_clip();
    test_busy_start();
    test_erase_only();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_rect_plotter.md
Name: sprite_rect_plotter

Overview:
- Pixel-stream engine between game logic (paddle/ball position FSMs) and vga_adapter on the 160x120, 3-bit-colour framebuffer.
- On each request it erases the rectangle it last drew, by painting it BG_COLOUR, then draws the rectangle at the new position.
- It emits one pixel per clock on x/y/colour/plot, which connect directly to the vga_adapter ports of the same names.

Parameters:
- RECT_W, 2, rectangle width in pixels (1..16).
- RECT_H, 8, rectangle height in pixels (1..16).
- BG_COLOUR, 3'b000, colour used for erase.
- SCREEN_W, 160, horizontal pixel limit for clipping.
- SCREEN_H, 120, vertical pixel limit for clipping.

Ports:
- clock  in  1  system clock (CLOCK_50 at top).
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when ready=1.
- erase_only  in  1  sampled with start; 1 = erase old rectangle, skip draw.
- new_x  in  8  top-left x of new rectangle.
- new_y  in  7  top-left y of new rectangle.
- new_colour  in  3  draw colour.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse when a request completes.
- x  out  8  pixel x to vga_adapter.
- y  out  7  pixel y to vga_adapter.
- colour  out  3  pixel colour to vga_adapter.
- plot  out  1  pixel write enable to vga_adapter.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, ready=1, done=0, plot=0, x=0, y=0, colour=0, old_valid=0, old_x=0, old_y=0, dx=dy=0.
- States: IDLE, ERASE, DRAW, FINISH.
- IDLE:
  - start=1 latches new_x, new_y, new_colour and erase_only; ready drops the next cycle.
  - Next state: ERASE if old_valid=1; otherwise DRAW, or FINISH when erase_only=1.
- Scan order, identical in ERASE and DRAW:
  - dx counts 0..RECT_W-1 (inner loop), dy counts 0..RECT_H-1 (outer loop).
  - One pixel per cycle; exactly RECT_W*RECT_H cycles per phase.
- Pixel coordinates:
  - Base is old_x/old_y in ERASE and the latched new_x/new_y in DRAW.
  - Sums use 9-bit x and 8-bit y arithmetic.
- Clipping: if the x sum >= SCREEN_W or the y sum >= SCREEN_H, then plot=0 for that cycle. The cycle is still consumed, and x/y carry the truncated sum. Otherwise plot=1.
- Colour: BG_COLOUR in ERASE, latched colour in DRAW.
- Phase transitions:
  - ERASE, last pixel -> DRAW, or -> FINISH when erase_only=1.
  - DRAW, last pixel -> FINISH.
- FINISH (one cycle):
  - plot=0, done=1.
  - If a draw occurred: old_x/old_y <= latched new position, old_valid <= 1.
  - If erase_only: old_valid <= 0.
  - Next state: IDLE.
- Latency, start accepted in cycle 0:
  - First pixel is on the outputs in cycle 1.
  - Full erase+draw: done in cycle 2*RECT_W*RECT_H+1; ready=1 the following cycle.
  - Draw with no valid old rectangle: done in cycle RECT_W*RECT_H+1.
- Busy handling: start while ready=0 is ignored (not queued). Inputs may change freely after acceptance.
- Idle with no pending start: plot=0; x/y/colour hold their last values.
- Special requests:
  - erase_only with old_valid=0 -> straight to FINISH; done arrives 1 cycle after acceptance.
  - new position equal to old position is not special-cased: full erase then draw.
- Reset mid-operation: abort. plot=0 and done=0 from the next edge, old_valid=0, and no done pulse is emitted for the aborted request.

Test Plan:
- Defaults, reset, then start with (10,20,3'b100) -> 16 pixels with plot=1 at x 10..11, y 20..27, colour 100, in order (10,20),(11,20),(10,21)…; done in cycle 17; ready back in cycle 18.
- Next start with (11,20,3'b010) -> 16 erase pixels at (10..11,20..27) colour 000, then 16 draw pixels at (11..12,20..27) colour 010; done in cycle 33.
- Clipping: draw at (159,115) -> pixels with x=159 and y<=119 get plot=1 (5 pixels). The x=160 column and rows 120..122 get plot=0. Still 16 cycles total.
- start pulsed repeatedly mid-DRAW with different coordinates -> ignored; output stream and done timing unchanged, and the old position recorded is that of the first request.
- erase_only after a draw at (40,60) -> 16 pixels colour 000 at (40..41,60..67), done. A second erase_only produces done 1 cycle after acceptance with no plot.
- reset asserted on the 5th DRAW pixel -> plot=0 next cycle, no done. The next start draws immediately with no erase phase.
